sha256_msg_sched_ctrl: RTL and testbench

- Sequences SHA-256 message expansion for one 512-bit block.
- Loads 16 message words, then streams W[0..ROUNDS-1] to the round logic.
- Computes each W[t] for t≥16 by issuing sig0/sig1 operations to the core's shared SHA ALU port through a req/gnt/rvalid handshake, then adding the terms locally.
- Sits between the crypto load path and the round engine. It is the only client driving SHA-sigma ops onto the shared ALU port.

---
 rtl/sha256_msg_sched_ctrl_if.sv | 28 ++
 rtl/sha256_msg_sched_ctrl.sv | 66 ++++++
 tb/tb_sha256_msg_sched_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_sched_ctrl_if.sv
// sha256_msg_sched_ctrl_if: control, message-load, shared-ALU and schedule-word signals
interface sha256_msg_sched_ctrl_if;
  logic        start_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [31:0] msg_word_i;
  logic        alu_req_o;
  logic        alu_gnt_i;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_operand_o;
  logic        alu_rvalid_i;
  logic [31:0] alu_result_i;
  logic        w_valid_o;
  logic        w_ready_i;
  logic [31:0] w_data_o;
  logic [5:0]  w_idx_o;
  modport slave (
    input  start_i, abort_i, msg_valid_i, msg_word_i, alu_gnt_i, alu_rvalid_i, alu_result_i, w_ready_i,
    output busy_o, done_o, msg_ready_o, alu_req_o, alu_op_o, alu_operand_o, w_valid_o, w_data_o, w_idx_o
  );
  modport master (
    output start_i, abort_i, msg_valid_i, msg_word_i, alu_gnt_i, alu_rvalid_i, alu_result_i, w_ready_i,
    input  busy_o, done_o, msg_ready_o, alu_req_o, alu_op_o, alu_operand_o, w_valid_o, w_data_o, w_idx_o
  );
endinterface

// File: rtl/sha256_msg_sched_ctrl.sv
// sha256_msg_sched_ctrl: SHA-256 message schedule sequencer using a shared sigma ALU
module sha256_msg_sched_ctrl #(
  parameter int ROUNDS = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  sha256_msg_sched_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, OUT, S0_REQ, S0_WAIT, S1_REQ, S1_WAIT, DRAIN} state_t;
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);
  state_t      r_state, w_next;
  logic [6:0]  r_t;
  logic [31:0] r_buf [16];
  logic [31:0] r_s0;
  logic        r_done;
  logic [3:0]  w_i;
  logic        w_msg_acc;
  logic        w_w_acc;
  logic [31:0] w_sum;
  assign w_i       = r_t[3:0];
  assign w_msg_acc = r_state == LOAD && bus.msg_valid_i && !bus.abort_i;
  assign w_w_acc   = r_state == OUT && bus.w_ready_i && !bus.abort_i;
  // slot t mod 16 still holds W[t-16] when the new word is summed into it
  assign w_sum     = bus.alu_result_i + r_buf[w_i - 4'd7] + r_s0 + r_buf[w_i];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start_i && !bus.abort_i ? LOAD : IDLE;
      LOAD:    w_next = bus.abort_i ? IDLE : w_msg_acc && w_i == 4'd15 ? OUT : LOAD;
      OUT:     w_next = bus.abort_i ? IDLE : !w_w_acc ? OUT : r_t == LAST ? IDLE : r_t >= 7'd15 ? S0_REQ : OUT;
      S0_REQ:  w_next = bus.alu_gnt_i ? (bus.abort_i ? DRAIN : S0_WAIT) : (bus.abort_i ? IDLE : S0_REQ);
      S0_WAIT: w_next = bus.alu_rvalid_i ? (bus.abort_i ? IDLE : S1_REQ) : (bus.abort_i ? DRAIN : S0_WAIT);
      S1_REQ:  w_next = bus.alu_gnt_i ? (bus.abort_i ? DRAIN : S1_WAIT) : (bus.abort_i ? IDLE : S1_REQ);
      S1_WAIT: w_next = bus.alu_rvalid_i ? (bus.abort_i ? IDLE : OUT) : (bus.abort_i ? DRAIN : S1_WAIT);
      DRAIN:   w_next = bus.alu_rvalid_i ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_w_acc && r_t == LAST;
      if (r_state == IDLE) r_t <= '0;
      else if (w_msg_acc) r_t <= w_i == 4'd15 ? 7'd0 : r_t + 7'd1;
      else if (w_w_acc) r_t <= r_t + 7'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == S0_WAIT && bus.alu_rvalid_i) r_s0 <= bus.alu_result_i;
    if (w_msg_acc) r_buf[w_i] <= bus.msg_word_i;
    else if (r_state == S1_WAIT && bus.alu_rvalid_i) r_buf[w_i] <= w_sum;
  end
  assign bus.busy_o        = r_state != IDLE;
  assign bus.done_o        = r_done;
  assign bus.msg_ready_o   = r_state == LOAD;
  assign bus.alu_req_o     = r_state == S0_REQ || r_state == S1_REQ;
  assign bus.alu_op_o      = {1'b0, r_state == S1_REQ};
  assign bus.alu_operand_o = r_state == S0_REQ ? r_buf[w_i + 4'd1] : r_state == S1_REQ ? r_buf[w_i - 4'd2] : '0;
  assign bus.w_valid_o     = r_state == OUT;
  assign bus.w_data_o      = r_state == OUT ? r_buf[w_i] : '0;
  assign bus.w_idx_o       = r_state == OUT ? r_t[5:0] : '0;
endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
// tb_sha256_msg_sched_ctrl: randomized bench against a direct SHA-256 schedule model
module tb_sha256_msg_sched_ctrl;
  localparam int R = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sha256_msg_sched_ctrl_if b();
  sha256_msg_sched_ctrl_if b16();
  sha256_msg_sched_ctrl #(.ROUNDS(R)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  sha256_msg_sched_ctrl #(.ROUNDS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  bit phase16 = 1'b0;
  assign b16.start_i      = b.start_i & phase16;
  assign b16.abort_i      = b.abort_i;
  assign b16.msg_valid_i  = b.msg_valid_i;
  assign b16.msg_word_i   = b.msg_word_i;
  assign b16.w_ready_i    = b.w_ready_i;
  assign b16.alu_gnt_i    = 1'b0;
  assign b16.alu_rvalid_i = 1'b0;
  assign b16.alu_result_i = '0;

  int n_chk = 0, n_err = 0;
  int cyc = 0, last_hs = 0, last16 = 0, done_cnt = 0, done16 = 0, req16 = 0, d0 = 0;
  int force_rv = -1;
  bit rnd = 1'b0;
  logic [31:0] msg [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_d [$];
  logic [5:0]  got_i [$];
  logic [31:0] q16 [$];
  logic [5:0]  last_idx = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic calc();
    for (int t = 0; t < 64; t++)
      if (t < 16) exp_w[t] = msg[t];
      else exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
  endtask

  // consumer side: random backpressure, stream capture, done timing
  logic [31:0] pd;
  logic [5:0]  pi;
  bit stall = 1'b0;
  initial begin
    b.w_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall && b.w_valid_o) begin
        chk("w_hold_data", b.w_data_o, pd);
        chk("w_hold_idx", 32'(b.w_idx_o), 32'(pi));
      end
      b.w_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (b.w_valid_o && b.w_ready_i) begin
        got_d.push_back(b.w_data_o);
        got_i.push_back(b.w_idx_o);
        last_hs  = cyc;
        last_idx = b.w_idx_o;
      end
      stall = b.w_valid_o && !b.w_ready_i;
      pd = b.w_data_o;
      pi = b.w_idx_o;
      if (b.done_o) begin
        done_cnt++;
        chk("done_lat", cyc - last_hs, 1);
        chk("done_idx", 32'(last_idx), R - 1);
      end
      if (b16.w_valid_o && b.w_ready_i) begin
        q16.push_back(b16.w_data_o);
        last16 = cyc;
      end
      if (b16.done_o) begin
        done16++;
        chk("done16_lat", cyc - last16, 1);
      end
      if (b16.alu_req_o) req16++;
    end
  end

  // shared ALU: random grant/result latency, checks request stability
  int gd = 0, rd = 0;
  bit pend = 1'b0, hold = 1'b0;
  logic [1:0]  hop;
  logic [31:0] hopd, res;
  initial begin
    b.alu_gnt_i = 1'b0;
    b.alu_rvalid_i = 1'b0;
    b.alu_result_i = '0;
    forever begin
      @(negedge clk);
      b.alu_gnt_i = 1'b0;
      b.alu_rvalid_i = 1'b0;
      if (pend) begin
        if (rd == 0) begin
          b.alu_rvalid_i = 1'b1;
          b.alu_result_i = res;
          pend = 1'b0;
        end else rd--;
      end else if (b.alu_req_o) begin
        if (hold) begin
          chk("alu_op_hold", 32'(b.alu_op_o), 32'(hop));
          chk("alu_opd_hold", b.alu_operand_o, hopd);
        end
        if (gd == 0) begin
          b.alu_gnt_i = 1'b1;
          pend = 1'b1;
          hold = 1'b0;
          res = b.alu_op_o == 2'd1 ? sig1(b.alu_operand_o) : sig0(b.alu_operand_o);
          rd = force_rv >= 0 ? force_rv : rnd ? int'($urandom_range(0, 5)) : 0;
          gd = rnd ? int'($urandom_range(0, 5)) : 0;
        end else begin
          gd--;
          hold = 1'b1;
          hop = b.alu_op_o;
          hopd = b.alu_operand_o;
        end
      end else hold = 1'b0;
    end
  end

  task automatic idle_chk(input string p);
    chk({p, "_busy"}, 32'(b.busy_o), 0);
    chk({p, "_done"}, 32'(b.done_o), 0);
    chk({p, "_mrdy"}, 32'(b.msg_ready_o), 0);
    chk({p, "_req"}, 32'(b.alu_req_o), 0);
    chk({p, "_wvld"}, 32'(b.w_valid_o), 0);
    chk({p, "_op"}, 32'(b.alu_op_o), 0);
    chk({p, "_opd"}, b.alu_operand_o, 0);
    chk({p, "_wdat"}, b.w_data_o, 0);
    chk({p, "_widx"}, 32'(b.w_idx_o), 0);
  endtask

  task automatic begin_block(input bit r, input bit mid);
    int i;
    calc();
    rnd = r;
    got_d.delete();
    got_i.delete();
    q16.delete();
    d0 = done_cnt;
    @(negedge clk);
    b.start_i = 1'b1;
    @(negedge clk);
    i = 0;
    for (int k = 0; k < 500 && i < 16; k++) begin
      b.start_i = mid && k == 3;
      b.msg_word_i = msg[i];
      b.msg_valid_i = r ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mid && k == 4) chk("busy_start", 32'(b.busy_o), 1);
      if (b.msg_valid_i && b.msg_ready_o) i++;
      @(negedge clk);
    end
    b.start_i = 1'b0;
    b.msg_valid_i = 1'b0;
    chk("feed_cnt", i, 16);
  endtask

  task automatic end_block();
    for (int k = 0; k < 8000 && got_d.size() < R; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("w_count", got_d.size(), R);
    for (int t = 0; t < got_d.size() && t < R; t++) begin
      chk($sformatf("w%0d", t), got_d[t], exp_w[t]);
      chk($sformatf("idx%0d", t), 32'(got_i[t]), t);
    end
    chk("done_cnt", done_cnt - d0, 1);
    chk("busy_end", 32'(b.busy_o), 0);
  endtask

  initial begin
    b.start_i = 1'b0;
    b.abort_i = 1'b0;
    b.msg_valid_i = 1'b0;
    b.msg_word_i = '0;
    repeat (3) @(negedge clk);
    idle_chk("rst");
    rst_n = 1'b1;

    // NIST "abc" block, plus the ROUNDS=16 instance in lockstep
    foreach (msg[i]) msg[i] = '0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    phase16 = 1'b1;
    begin_block(1'b0, 1'b0);
    end_block();
    phase16 = 1'b0;
    if (got_d.size() > 18) begin
      chk("abc_w16", got_d[16], 32'h61626380);
      chk("abc_w17", got_d[17], 32'h000F0000);
      chk("abc_w18", got_d[18], 32'h7DA86405);
    end
    chk("r16_count", q16.size(), 16);
    for (int t = 0; t < q16.size() && t < 16; t++) chk($sformatf("r16_w%0d", t), q16[t], exp_w[t]);
    chk("r16_done", done16, 1);
    chk("r16_noreq", req16, 0);

    // throttled random blocks, one with a start_i during LOAD
    for (int n = 0; n < 3; n++) begin
      foreach (msg[i]) msg[i] = $urandom;
      begin_block(1'b1, n == 1);
      end_block();
    end

    // abort while the first sig0 is outstanding
    foreach (msg[i]) msg[i] = $urandom;
    force_rv = 3;
    begin_block(1'b0, 1'b0);
    for (int k = 0; k < 300 && !b.alu_req_o; k++) @(negedge clk);
    for (int k = 0; k < 20 && b.alu_req_o; k++) @(negedge clk);
    chk("s0wait_busy", 32'(b.busy_o), 1);
    chk("s0wait_req", 32'(b.alu_req_o), 0);
    b.abort_i = 1'b1;
    @(negedge clk);
    b.abort_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("drain_busy%0d", j), 32'(b.busy_o), 1);
      chk($sformatf("drain_req%0d", j), 32'(b.alu_req_o), 0);
      @(negedge clk);
    end
    chk("drain_exit", 32'(b.busy_o), 0);
    force_rv = -1;
    repeat (3) @(negedge clk);
    chk("abort_nodone", done_cnt - d0, 0);
    foreach (msg[i]) msg[i] = $urandom;
    begin_block(1'b1, 1'b0);
    end_block();

    // one-cycle reset during the sig1 request
    foreach (msg[i]) msg[i] = $urandom;
    begin_block(1'b0, 1'b0);
    for (int k = 0; k < 300 && !(b.alu_req_o && b.alu_op_o == 2'd1); k++) @(negedge clk);
    chk("s1req_seen", 32'(b.alu_op_o), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk("mid_rst");
    repeat (2) @(negedge clk);
    idle_chk("stray_rv");
    begin_block(1'b0, 1'b0);
    end_block();

    // start together with abort in IDLE
    @(negedge clk);
    b.start_i = 1'b1;
    b.abort_i = 1'b1;
    @(negedge clk);
    b.start_i = 1'b0;
    b.abort_i = 1'b0;
    chk("st_ab_busy0", 32'(b.busy_o), 0);
    @(negedge clk);
    chk("st_ab_busy1", 32'(b.busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
